// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared CPU opcode nibbles, slot classes and streamer states
package cpu_isa_pkg;

   // Idle/filler byte: Output C only touches the CPU out register, so it is harmless anywhere
   localparam logic [7:0] NOP_BYTE = 8'hB0;

   // Opcode nibbles as decoded from opcode[7:4]
   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_AND    = 4'h2;
   localparam logic [3:0] OP_OR     = 4'h3;
   localparam logic [3:0] OP_XOR    = 4'h4;
   localparam logic [3:0] OP_BEQC   = 4'h5;
   localparam logic [3:0] OP_INA    = 4'h6;
   localparam logic [3:0] OP_INB    = 4'h7;
   localparam logic [3:0] OP_INMEM  = 4'h8;
   localparam logic [3:0] OP_STC    = 4'h9;
   localparam logic [3:0] OP_LDC    = 4'hA;
   localparam logic [3:0] OP_OUTC   = 4'hB;
   localparam logic [3:0] OP_OUTMEM = 4'hC;

   typedef enum logic [1:0] {
      SLOT_ONE     = 2'd0,
      SLOT_OPERAND = 2'd1,
      SLOT_FILLER  = 2'd2
   } slot_class_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OP     = 3'd1,
      ST_ARG    = 3'd2,
      ST_DRAIN0 = 3'd3,
      ST_DRAIN1 = 3'd4,
      ST_FIN    = 3'd5
   } stream_state_t;

   // How many byte slots the CPU control FSM consumes for an opcode
   function automatic slot_class_t slot_class(input logic [7:0] opcode);
      slot_class_t cls;
      case (opcode[7:4])
         OP_INA, OP_INB, OP_INMEM: cls = SLOT_OPERAND;
         OP_LDC, OP_OUTMEM:        cls = SLOT_FILLER;
         default:                  cls = SLOT_ONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/prog_buf.sv
// rtl/prog_buf.sv - program entry register file, synchronous write, combinational read
module prog_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // Program contents survive reset on purpose so a loaded program can be rerun
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_prog_streamer.sv
// rtl/cpu_prog_streamer.sv - expands program entries into the CPU in-byte stream and captures results
module cpu_prog_streamer
   import cpu_isa_pkg::*;
#(
   parameter int         DEPTH    = 16,
   parameter int         AW       = 4,
   parameter logic [7:0] NOP_BYTE = cpu_isa_pkg::NOP_BYTE
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [15:0]   ld_data,
   input  logic [4:0]    prog_len,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [7:0]    cpu_in,
   input  logic [7:0]    cpu_out,
   output logic          res_valid,
   output logic [7:0]    res_data
);

   stream_state_t state, state_n;
   logic [AW-1:0] pc, pc_n;
   logic [4:0]    len, len_n;
   logic [15:0]   cur_entry, cur_n;
   logic [7:0]    cpu_in_n;
   logic          busy_n, done_n;
   logic          out_slot, out_slot_n;
   logic          cap_p1, cap_p2;

   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
   logic [4:0]    eff_len;
   logic          last_entry;
   slot_class_t   cur_class;

   prog_buf #(.DEPTH(DEPTH), .AW(AW)) u_prog_buf (
      .clk   (clk),
      .we    (ld_en && !busy),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // The entry being emitted is held in cur_entry, so the single read port always looks one entry ahead
   assign rd_addr    = (state == ST_IDLE) ? '0 : pc + 1'b1;
   assign eff_len    = (prog_len > 5'(DEPTH)) ? 5'(DEPTH) : prog_len;
   assign last_entry = ({1'b0, pc} + 5'd1) == len;
   assign cur_class  = slot_class(cur_entry[15:8]);

   // Next-slot selection: opcode, operand/filler, drain NOPs, then the done pulse
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      len_n      = len;
      cur_n      = cur_entry;
      cpu_in_n   = NOP_BYTE;
      busy_n     = busy;
      done_n     = 1'b0;
      out_slot_n = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               len_n = eff_len;
               pc_n  = '0;
               if (eff_len == 5'd0) begin
                  state_n = ST_FIN;
                  done_n  = 1'b1;
               end else begin
                  busy_n     = 1'b1;
                  cpu_in_n   = rd_data[15:8];
                  cur_n      = rd_data;
                  out_slot_n = (rd_data[15:12] == OP_OUTC);
                  state_n    = ST_OP;
               end
            end
         end
         ST_OP, ST_ARG: begin
            if (state == ST_OP && cur_class != SLOT_ONE) begin
               cpu_in_n = (cur_class == SLOT_OPERAND) ? cur_entry[7:0] : NOP_BYTE;
               state_n  = ST_ARG;
            end else begin
               pc_n = pc + 1'b1;
               if (last_entry) begin
                  state_n = ST_DRAIN0;
               end else begin
                  cpu_in_n   = rd_data[15:8];
                  cur_n      = rd_data;
                  out_slot_n = (rd_data[15:12] == OP_OUTC);
                  state_n    = ST_OP;
               end
            end
         end
         ST_DRAIN0: state_n = ST_DRAIN1;
         ST_DRAIN1: begin
            state_n = ST_FIN;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         ST_FIN:    state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // FSM and output byte registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pc        <= '0;
         len       <= '0;
         cur_entry <= '0;
         cpu_in    <= NOP_BYTE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_slot  <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         len       <= len_n;
         cur_entry <= cur_n;
         cpu_in    <= cpu_in_n;
         busy      <= busy_n;
         done      <= done_n;
         out_slot  <= out_slot_n;
      end
   end

   // Result capture pipe: free-running so Output C results still land during drain and FIN
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_p1    <= 1'b0;
         cap_p2    <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         cap_p1    <= out_slot;
         cap_p2    <= cap_p1;
         res_valid <= cap_p2;
         if (cap_p2) res_data <= cpu_out;
      end
   end

endmodule
